smvm_tx: RTL and testbench
==========================

Name: smvm_tx

Overview:
- Transmit-side driver for the SMVM input stream.
- Accepts one job from the host: a header, a dense vector and a list of nonzero entries, each over valid/ready handshakes.
- Buffers the whole job, then replays it back-to-back on the val/col/ipv/in_valid lines that feed the SMVM core.
- The core has no backpressure, so transmission starts only after the job is fully loaded, and the line stays quiet until the core has drained.

Parameters:
- K, 4, nonzeros per ALU group; the nonzero count is padded to a multiple of K.
- MAX_COLS, 128, vector buffer depth (maximum cfg_cols).
- NZ_DEPTH, 64, nonzero buffer depth; must be a multiple of K.
- GAP_CYCLES, 8, minimum in_valid-low cycles after a job; must be >= 7, the core drain time.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  job header valid
- cfg_ready  out  1  high only in IDLE
- cfg_rows  in  8  row count, 1..128
- cfg_cols  in  8  column and vector length, 1..MAX_COLS
- vec_valid  in  1  vector element valid
- vec_ready  out  1  high in LD_VEC
- vec_data  in  8  signed vector element
- nz_valid  in  1  nonzero valid
- nz_ready  out  1  high in LD_NZ
- nz_val  in  8  signed matrix value
- nz_col  in  7  column index
- nz_row_end  in  1  marks the last nonzero of a row; becomes ipv
- nz_last  in  1  marks the last nonzero of the job
- tx_valid  out  1  drives core in_valid
- tx_val  out  8  drives core val_in
- tx_ipv  out  1  drives core ipv_in
- tx_col  out  3  drives core col_in
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes
- err_overflow  out  1  sticky; set when nonzeros are dropped, cleared on cfg accept

Behaviour:
- Reset is asynchronous, active low. All outputs go to 0 immediately, except cfg_ready, which is 1 after reset. State goes to IDLE and both buffer pointers clear.
- A reset in the middle of a job aborts it with no done pulse; the bench resets the core alongside.
- All tx_* outputs are registered.
- Word encoding: a 12-bit word w is sent as tx_val=w[11:4], tx_ipv=w[3], tx_col=w[2:0]. Header and index values are zero-extended to 12 bits.
- IDLE -> LD_VEC on cfg_valid: latch rows and cols, clear err_overflow and the counters.
- LD_VEC: store the element at index vcnt on each vec handshake. After cfg_cols handshakes go to LD_NZ. Gaps in vec_valid are allowed.
- LD_NZ: write {val, col, row_end} on each handshake.
  - If the buffer already holds NZ_DEPTH entries, the beat is accepted but dropped, and err_overflow is set.
  - The handshake with nz_last=1 moves to TX_ROWS.
  - Npad = stored count rounded up to a multiple of K.
  - Padding entries are val 0, col 0, ipv 0.
- TX_ROWS: tx_valid=1 with word rows. Starts on the cycle after the nz_last handshake.
- TX_COLS: tx_valid=1 with word cols.
- TX_VEC: cols cycles sending vector[0..cols-1] on tx_val, with tx_ipv=0 and tx_col=0.
- TX_VAL: tx_val=value, tx_ipv=row_end, tx_col=0.
- TX_IDX: sends the index word for that entry.
- TX_VAL and TX_IDX alternate for Npad pairs. The stream is continuous from TX_ROWS to the last TX_IDX, with no tx_valid gaps.
- Total tx_valid-high cycles = 2 + cols + 2*Npad.
- GAP: tx_valid and all tx_* = 0 for GAP_CYCLES cycles. In the last GAP cycle, done=1 and the next state is IDLE.
- cfg_valid while not in IDLE: ignored.
- vec_valid outside LD_VEC and nz_valid outside LD_NZ: ignored.
- A job always contains at least one nonzero. nz_last on the first beat gives Npad=K.
- Vector reads use a registered buffer address, so the tx data register loads without a bubble.

Decomposition:
- smvm_pkg holds:
  - K
  - word width (12)
  - the state enum: IDLE, LD_VEC, LD_NZ, TX_ROWS, TX_COLS, TX_VEC, TX_VAL, TX_IDX, GAP
  - the word-split function, 12 bits -> {val, ipv, col}
  - CORE_DRAIN=7
- Sub-module smvm_nz_buffer: NZ_DEPTH x 16 storage (val, col, row_end) with write pointer, count, overflow flag, and a read port with pad-to-K logic that returns zero entries past the stored count.
- The vector buffer and FSM are inline.

Test Plan:
- Basic job: rows=2, cols=4, vec=[1,2,3,4], nz=(5,c0,e0),(6,c3,e1),(7,c1,e0),(8,c2,e1).
  - Expected stream: rows word {0x00,0,2}; cols word {0x00,0,4}; vector 1,2,3,4; pairs (5,ipv0)/{0x00,0,0}, (6,ipv1)/{0,0,3}, (7,ipv0)/{0,0,1}, (8,ipv1)/{0,0,2}.
  - 14 valid cycles, then 8 low cycles, then done.
- Padding: 5 nonzeros -> Npad=8; pairs 6..8 are val 0, ipv 0, idx 0; valid length = 2 + cols + 16.
- Maximum columns: cols=128 -> header tx_val=0x08, tx_ipv=0, tx_col=0; vector[127] is sent last in TX_VEC.
- Overflow: with NZ_DEPTH=8, send 10 nonzeros -> err_overflow=1, exactly 8 pairs sent, nz_ready stays 1 for the dropped beats.
- Stalled load: random vec_valid/nz_valid gaps and cfg_valid pulses while busy -> transmitted stream identical to the basic job, extra cfg ignored.
- Mid-job reset: rst_n low during TX_VEC -> tx_valid=0 asynchronously, no done pulse, cfg_ready=1 after release.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared constants, FSM state type and word-split helper for the SMVM transmit driver.
package smvm_pkg;

  localparam int unsigned K          = 4;
  localparam int unsigned WORD_W     = 12;
  localparam int unsigned CORE_DRAIN = 7;

  typedef enum logic [3:0] {
    IDLE,
    LD_VEC,
    LD_NZ,
    TX_ROWS,
    TX_COLS,
    TX_VEC,
    TX_VAL,
    TX_IDX,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0] val;
    logic       ipv;
    logic [2:0] col;
  } tx_word_t;

  function automatic tx_word_t split_word(input logic [WORD_W-1:0] w);
    tx_word_t s;
    s.val = w[11:4];
    s.ipv = w[3];
    s.col = w[2:0];
    return s;
  endfunction

endpackage

// File: rtl/smvm_nz_buffer.sv
// Nonzero entry store {val, col, row_end}; reads past the stored count return
// zero entries so the job pads out to a multiple of K.
module smvm_nz_buffer
  import smvm_pkg::*;
#(
  parameter  int unsigned NZ_DEPTH = 64,
  localparam int unsigned CW       = $clog2(NZ_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic [CW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [CW-1:0] npad,
  output logic          overflow
);

  localparam int unsigned AW  = $clog2(NZ_DEPTH);
  localparam int unsigned CW1 = CW + 1;

  logic [15:0]   mem [NZ_DEPTH];
  logic [CW-1:0] count;
  logic [CW:0]   count_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (count < CW'(NZ_DEPTH)) count <= count + 1'b1;
      else                       overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr && count < CW'(NZ_DEPTH)) mem[count[AW-1:0]] <= wr_data;
  end

  assign rd_data   = (rd_addr < count) ? mem[rd_addr[AW-1:0]] : '0;
  assign count_ext = {1'b0, count};
  // Result never exceeds NZ_DEPTH because NZ_DEPTH is a multiple of K.
  assign npad      = CW'(((count_ext + CW1'(K - 1)) / CW1'(K)) * CW1'(K));

endmodule

// File: rtl/smvm_tx.sv
// SMVM transmit driver: loads one job (header, vector, nonzeros), then replays
// it as a gap-free word stream followed by a quiet drain window.
module smvm_tx
  import smvm_pkg::*;
#(
  parameter int unsigned MAX_COLS   = 128,
  parameter int unsigned NZ_DEPTH   = 64,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_rows,
  input  logic [7:0] cfg_cols,
  input  logic       vec_valid,
  output logic       vec_ready,
  input  logic [7:0] vec_data,
  input  logic       nz_valid,
  output logic       nz_ready,
  input  logic [7:0] nz_val,
  input  logic [6:0] nz_col,
  input  logic       nz_row_end,
  input  logic       nz_last,
  output logic       tx_valid,
  output logic [7:0] tx_val,
  output logic       tx_ipv,
  output logic [2:0] tx_col,
  output logic       busy,
  output logic       done,
  output logic       err_overflow
);

  localparam int unsigned VA_W    = $clog2(MAX_COLS);
  localparam int unsigned CW      = $clog2(NZ_DEPTH + 1);
  localparam int unsigned GAP_LEN = (GAP_CYCLES > CORE_DRAIN) ? GAP_CYCLES : CORE_DRAIN;
  localparam int unsigned GW      = $clog2(GAP_LEN);

  state_t              state_q, state_d;
  logic [7:0]          rows_q, cols_q;
  logic [7:0]          vcnt_q;
  logic [CW-1:0]       pcnt_q;
  logic [GW-1:0]       gcnt_q;
  logic [7:0]          vec_mem [MAX_COLS];
  logic [7:0]          vec_rd;
  logic [15:0]         nz_rd;
  logic [CW-1:0]       npad;
  logic [WORD_W-1:0]   word_d;
  logic                valid_d;
  logic                cfg_acc, nz_wr;

  assign cfg_ready = (state_q == IDLE);
  assign vec_ready = (state_q == LD_VEC);
  assign nz_ready  = (state_q == LD_NZ);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == GAP) && (gcnt_q == GW'(GAP_LEN - 1));
  assign cfg_acc   = cfg_ready && cfg_valid;
  assign nz_wr     = nz_ready && nz_valid;
  assign vec_rd    = vec_mem[vcnt_q[VA_W-1:0]];

  smvm_nz_buffer #(.NZ_DEPTH(NZ_DEPTH)) u_nz_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cfg_acc),
    .wr_en    (nz_wr),
    .wr_data  ({nz_val, nz_col, nz_row_end}),
    .rd_addr  (pcnt_q),
    .rd_data  (nz_rd),
    .npad     (npad),
    .overflow (err_overflow)
  );

  always_ff @(posedge clk) begin
    if (state_q == LD_VEC && vec_valid) vec_mem[vcnt_q[VA_W-1:0]] <= vec_data;
  end

  // The word for the next state is built here so the tx registers line up with the state.
  always_comb begin
    state_d = state_q;
    word_d  = '0;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE:   if (cfg_valid) state_d = LD_VEC;
      LD_VEC: if (vec_valid && vcnt_q == cols_q - 8'd1) state_d = LD_NZ;
      LD_NZ: begin
        if (nz_valid && nz_last) begin
          state_d = TX_ROWS;
          valid_d = 1'b1;
          word_d  = {4'h0, rows_q};
        end
      end
      TX_ROWS: begin
        state_d = TX_COLS;
        valid_d = 1'b1;
        word_d  = {4'h0, cols_q};
      end
      TX_COLS: begin
        state_d = TX_VEC;
        valid_d = 1'b1;
        word_d  = {vec_rd, 4'h0};
      end
      TX_VEC: begin
        valid_d = 1'b1;
        if (vcnt_q == cols_q) begin
          state_d = TX_VAL;
          word_d  = {nz_rd[15:8], nz_rd[0], 3'b000};
        end else begin
          word_d  = {vec_rd, 4'h0};
        end
      end
      TX_VAL: begin
        state_d = TX_IDX;
        valid_d = 1'b1;
        word_d  = {5'h00, nz_rd[7:1]};
      end
      TX_IDX: begin
        if (pcnt_q == npad) begin
          state_d = GAP;
        end else begin
          state_d = TX_VAL;
          valid_d = 1'b1;
          word_d  = {nz_rd[15:8], nz_rd[0], 3'b000};
        end
      end
      GAP:     if (gcnt_q == GW'(GAP_LEN - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      vcnt_q   <= '0;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      tx_valid <= 1'b0;
      tx_val   <= '0;
      tx_ipv   <= 1'b0;
      tx_col   <= '0;
    end else begin
      state_q                  <= state_d;
      tx_valid                 <= valid_d;
      {tx_val, tx_ipv, tx_col} <= split_word(word_d);
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
            vcnt_q <= '0;
            pcnt_q <= '0;
          end
        end
        LD_VEC:           if (vec_valid) vcnt_q <= (state_d == LD_NZ) ? 8'd0 : vcnt_q + 8'd1;
        TX_COLS, TX_VEC:  vcnt_q <= vcnt_q + 8'd1;
        TX_VAL:           pcnt_q <= pcnt_q + 1'b1;
        TX_IDX:           gcnt_q <= '0;
        GAP:              gcnt_q <= gcnt_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_tx.sv
// Randomized job-level bench for smvm_tx, checked against a stream model built from the job description.
module tb_smvm_tx;

  localparam int NZD = 8;
  localparam int KB  = 4;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_rows, cfg_cols;
  logic       vec_valid, vec_ready;
  logic [7:0] vec_data;
  logic       nz_valid, nz_ready;
  logic [7:0] nz_val;
  logic [6:0] nz_col;
  logic       nz_row_end, nz_last;
  logic       tx_valid, tx_ipv;
  logic [7:0] tx_val;
  logic [2:0] tx_col;
  logic       busy, done, err_overflow;

  smvm_tx #(.MAX_COLS(128), .NZ_DEPTH(NZD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_row_end(nz_row_end), .nz_last(nz_last),
    .tx_valid(tx_valid), .tx_val(tx_val), .tx_ipv(tx_ipv), .tx_col(tx_col),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  logic [11:0] got_q[$];
  int cyc = 0, first_v = -1, last_v = -1, done_cnt = 0, done_cyc = -1, hs_cyc = -1;

  always @(negedge clk) begin
    if (tx_valid) begin
      got_q.push_back({tx_val, tx_ipv, tx_col});
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic mon_clear();
    got_q.delete();
    first_v = -1; last_v = -1; done_cnt = 0; done_cyc = -1; hs_cyc = -1;
  endtask

  // Job description.
  logic [7:0] j_vec [128];
  logic [7:0] j_val [16];
  logic [6:0] j_col [16];
  logic       j_end [16];
  int         j_rows, j_cols, j_n;

  task automatic random_job(input int cols, input int n);
    j_rows = $urandom_range(1, 128);
    j_cols = cols;
    j_n    = n;
    for (int i = 0; i < 128; i++) j_vec[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      j_val[i] = 8'($urandom);
      j_col[i] = 7'($urandom);
      j_end[i] = 1'($urandom);
    end
  endtask

  task automatic junk(input bit stall, input bit in_vec);
    while (stall && $urandom_range(0, 2) == 0) begin
      cfg_valid = 1'($urandom);
      if (in_vec) nz_valid = 1'($urandom);
      else        vec_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    if (in_vec) nz_valid = 1'b0;
    else        vec_valid = 1'b0;
  endtask

  task automatic load_job(input bit stall);
    int n;
    n = 0;
    while (!cfg_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check("cfg_ready_timeout", 32'd1, 32'd0);
    mon_clear();
    cfg_rows = 8'(j_rows); cfg_cols = 8'(j_cols); cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < j_cols; i++) begin
      junk(stall, 1'b1);
      vec_valid = 1'b1; vec_data = j_vec[i];
      n = 0;
      while (!vec_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("vec_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      vec_valid = 1'b0;
    end
    for (int i = 0; i < j_n; i++) begin
      junk(stall, 1'b0);
      if (i >= NZD) check($sformatf("nz_ready_drop%0d", i), 32'(nz_ready), 32'd1);
      nz_valid = 1'b1; nz_val = j_val[i]; nz_col = j_col[i];
      nz_row_end = j_end[i]; nz_last = (i == j_n - 1);
      n = 0;
      while (!nz_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("nz_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      if (i == j_n - 1) hs_cyc = cyc;
      nz_valid = 1'b0; nz_last = 1'b0;
    end
  endtask

  task automatic finish_job(input string name);
    logic [11:0] exp_q[$];
    int n, stored, npad, len;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(posedge clk); #1; n++; end
    check({name, " done_seen"}, 32'(done_cnt != 0), 32'd1);
    check({name, " idle_after_done"}, {cfg_ready, busy}, 32'b10);
    repeat (3) @(posedge clk);
    #1;
    check({name, " done_pulses"}, 32'(done_cnt), 32'd1);

    stored = (j_n > NZD) ? NZD : j_n;
    npad   = ((stored + KB - 1) / KB) * KB;
    exp_q.push_back(12'(j_rows));
    exp_q.push_back(12'(j_cols));
    for (int i = 0; i < j_cols; i++) exp_q.push_back({j_vec[i], 4'h0});
    for (int i = 0; i < npad; i++) begin
      if (i < stored) begin
        exp_q.push_back({j_val[i], j_end[i], 3'b000});
        exp_q.push_back({5'h00, j_col[i]});
      end else begin
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
      end
    end
    len = exp_q.size();
    check({name, " stream_len"}, 32'(got_q.size()), 32'(len));
    for (int i = 0; i < len && i < got_q.size(); i++)
      check($sformatf("%s word%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({name, " start_latency"}, 32'(first_v), 32'(hs_cyc));
    check({name, " contiguous"}, 32'(last_v - first_v + 1), 32'(len));
    check({name, " gap_to_done"}, 32'(done_cyc - last_v), 32'(GAP));
    check({name, " overflow_flag"}, 32'(err_overflow), 32'(j_n > NZD));
  endtask

  task automatic basic_job();
    logic [7:0] v [4];
    logic [7:0] a [4];
    logic [6:0] c [4];
    logic       e [4];
    v = '{8'd1, 8'd2, 8'd3, 8'd4};
    a = '{8'd5, 8'd6, 8'd7, 8'd8};
    c = '{7'd0, 7'd3, 7'd1, 7'd2};
    e = '{1'b0, 1'b1, 1'b0, 1'b1};
    j_rows = 2; j_cols = 4; j_n = 4;
    for (int i = 0; i < 4; i++) begin
      j_vec[i] = v[i]; j_val[i] = a[i]; j_col[i] = c[i]; j_end[i] = e[i];
    end
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_rows = '0; cfg_cols = '0;
    vec_valid = 1'b0; vec_data = '0;
    nz_valid = 1'b0; nz_val = '0; nz_col = '0; nz_row_end = 1'b0; nz_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst outputs", {vec_ready, nz_ready, tx_valid, tx_val, tx_ipv, tx_col, busy, done, err_overflow},
          32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    basic_job();
    load_job(1'b0);
    finish_job("basic");

    random_job($urandom_range(1, 12), 5);
    load_job(1'b0);
    finish_job("pad5");

    random_job(128, 3);
    load_job(1'b0);
    finish_job("cols128");
    check("cols128 header", 32'(got_q[1]), 32'h080);

    random_job($urandom_range(1, 8), 10);
    load_job(1'b0);
    finish_job("overflow");

    basic_job();
    load_job(1'b1);
    finish_job("stalled");

    for (int t = 0; t < 4; t++) begin
      random_job($urandom_range(1, 20), $urandom_range(1, 10));
      load_job(1'($urandom));
      finish_job($sformatf("rand%0d", t));
    end

    random_job(128, 4);
    load_job(1'b0);
    n = 0;
    while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("midrst tx_started", 32'(tx_valid), 32'd1);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst async", {tx_valid, busy, done, err_overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("midrst no_done", 32'(done_cnt), 32'(d0));
    check("midrst idle", {cfg_ready, tx_valid, busy}, 32'b100);

    basic_job();
    load_job(1'b1);
    finish_job("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
